hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the RV32I five-stage core. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions: multi-cycle data-memory waits, taken-branch redirects and load-use hazards. It also runs a memory-wait watchdog and saturating performance counters.

## Interface
Parameters:
- WAIT_MAX, 255, consecutive not-ready memory cycles that trigger the watchdog (≥2)
- CNT_W, 16, width of each performance counter

Ports (name direction width meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd held in ID/EX
- ex_mem_rd  in  1  ID/EX holds a load (ID/EX mem_rd output)
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage has an access in progress
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits zero)
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- mem_err  out  1  sticky watchdog error
- state  out  2  FSM state: 0 RUN, 1 MWAIT, 2 ERR
- stall_cnt  out  CNT_W  stall cycles
- flush_cnt  out  CNT_W  branch flush cycles
- lu_cnt  out  CNT_W  load-use stall cycles

## Operation
- Derived terms:
  - mstall = mem_req & !mem_ready.
  - lu = ex_mem_rd & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Output rules are combinational from state and inputs. They are evaluated in priority order:
  1. ERR: all enables 0, all flushes 0, regardless of inputs.
  2. mstall (RUN or MWAIT): all enables 0, all flushes 0. The whole pipe freezes, and ex_branch_taken and lu are ignored.
  3. ex_branch_taken: pc_en=1 (target loads), if_id_en=1 with if_id_flush=1, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. lu is ignored because the ID instruction is wrong-path.
  4. lu: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1 (bubble), ex_mem_en=1, mem_wb_en=1.
  5. Otherwise: all enables 1, flushes 0.
- A flush is only ever asserted together with its enable.
- FSM (RUN, MWAIT, ERR) and wait counter wcnt:
  - RUN: if mstall, wcnt←1 and go to MWAIT; otherwise stay in RUN.
  - MWAIT: if !mstall (ready, or mem_req dropped), go to RUN and wcnt←0. Else if wcnt==WAIT_MAX-1, go to ERR and mem_err←1. Else wcnt←wcnt+1.
  - ERR: absorbing; it is left only by rst.
- Counters (all saturate at 2^CNT_W-1, none increment in ERR):
  - stall_cnt +1 on each cycle with mstall or applied lu stall.
  - flush_cnt +1 on each cycle where rule 3 applies.
  - lu_cnt +1 on each cycle where rule 4 applies.

## Timing
- Reset:
  - rst sampled high at an edge gives: state=RUN, wcnt=0, mem_err=0, all counters 0.
  - While rst is high, outputs are forced to: all enables 0, flushes 0.
  - rst mid-wait or in ERR returns to RUN at the next edge, with mem_err cleared.
- Latency:
  - Control outputs respond in the same cycle as their inputs (zero latency).
  - state, mem_err and counters update at the rising edge that ends the qualifying cycle.
- Load-use: exactly one stall cycle per hazard. The bubble enters ID/EX at that edge, so ex_mem_rd deasserts the next cycle and lu clears.
- Memory wait: pipe resumes in the cycle mem_ready=1; that cycle follows rules 3–5.
- Watchdog: WAIT_MAX consecutive mstall cycles cause ERR at the edge ending the last of them; mem_err=1 from the next cycle. WAIT_MAX-1 not-ready cycles followed by ready produce no error.
- Branch taken together with mstall: the branch is held in EX (pipe frozen) and flushes in the first non-stall cycle.

## Test plan
- Load-use: ex_mem_rd=1, ex_rd=5, id_use_rs2=1, id_rs2=5 → that cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Next cycle, with ex_mem_rd=0, all enables are 1 and lu_cnt=1. Repeat with ex_rd=0 → no stall.
- Branch priority: ex_branch_taken=1 with a simultaneous lu → pc_en=1, if_id_flush=1, id_ex_flush=1, flush_cnt=1, lu_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 (WAIT_MAX=4) → 3 cycles with all enables 0 and state MWAIT from cycle 2. Normal outputs in cycle 4, stall_cnt=3, mem_err=0.
- Watchdog: WAIT_MAX=4, 4 not-ready cycles → state=ERR and mem_err=1. All enables stay 0 even after mem_ready=1. rst for one cycle → RUN, mem_err=0, counters 0.
- Stall+branch: ex_branch_taken=1 during a 2-cycle mstall → no flush for 2 cycles, then the flush is applied in the cycle mem_ready=1 and flush_cnt=1.
- Saturation: CNT_W=2 with 5 consecutive load-use events → lu_cnt holds at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: freezes, flushes and bubbles the RV32I pipe
// for memory waits, taken branches and load-use hazards, with a wait watchdog.
module hazard_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WAIT_MAX - 1);

  state_t            cur, nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              err_nxt;
  logic              mstall, lu, lu_stall, br_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign mstall = mem_req & ~mem_ready;
  assign lu     = ex_mem_rd & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign state  = cur;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    lu_stall    = 1'b0;
    br_flush    = 1'b0;
    nxt         = cur;
    wcnt_nxt    = wcnt;
    err_nxt     = mem_err;

    // A pending memory wait freezes everything, so a taken branch waits in EX.
    if (!rst && cur != ERR && !mstall) begin
      if (ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        br_flush    = 1'b1;
      end else if (lu) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        lu_stall    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end
    end

    case (cur)
      RUN: begin
        if (mstall) begin
          nxt      = MWAIT;
          wcnt_nxt = WCNT_W'(1);
        end
      end
      MWAIT: begin
        if (!mstall) begin
          nxt      = RUN;
          wcnt_nxt = '0;
        end else if (wcnt == WLAST) begin
          nxt     = ERR;
          err_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: nxt = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      cur     <= nxt;
      wcnt    <= wcnt_nxt;
      mem_err <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else if (cur != ERR) begin
      if (mstall || lu_stall) stall_cnt <= sat_inc(stall_cnt);
      if (br_flush)           flush_cnt <= sat_inc(flush_cnt);
      if (lu_stall)           lu_cnt    <= sat_inc(lu_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with WAIT_MAX=4 and 2-bit counters so that
// watchdog and saturation corners are reached in a few cycles.
module tb_hazard_ctrl;
  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_rd, ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic       mem_err;
  logic [1:0] state;
  logic [1:0] stall_cnt, flush_cnt, lu_cnt;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] C_ZERO = 7'b000_0000;
  localparam logic [6:0] C_RUN  = 7'b110_1011;
  localparam logic [6:0] C_BR   = 7'b111_1111;
  localparam logic [6:0] C_LU   = 7'b000_1111;

  hazard_ctrl #(.WAIT_MAX(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .mem_err(mem_err), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
  );

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_rd = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check("rst_ctl", ctl, C_ZERO);
    step();
    check("rst_state", state, 0);
    check("rst_err", mem_err, 0);
    check("rst_cnts", {stall_cnt, flush_cnt, lu_cnt}, 0);
    rst = 1'b0;
    #1;
    check("idle_ctl", ctl, C_RUN);

    // Load-use on rs2, then on rs1
    ex_mem_rd = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    #1 check("lu_rs2_ctl", ctl, C_LU);
    step();
    ex_mem_rd = 1'b0;
    #1 check("lu_after_ctl", ctl, C_RUN);
    check("lu_cnt1", lu_cnt, 1);
    check("lu_stall_cnt1", stall_cnt, 1);
    idle();
    ex_mem_rd = 1'b1; ex_rd = 5'd7; id_use_rs1 = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd7;
    #1 check("lu_rs1_ctl", ctl, C_LU);
    step();
    check("lu_cnt2", lu_cnt, 2);
    id_use_rs1 = 1'b0;
    #1 check("lu_nouse_ctl", ctl, C_RUN);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    #1 check("lu_x0_ctl", ctl, C_RUN);
    step();
    check("lu_x0_cnt", lu_cnt, 2);

    // Branch outranks a simultaneous load-use
    do_reset();
    ex_mem_rd = 1'b1; ex_rd = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5; ex_branch_taken = 1'b1;
    #1 check("br_ctl", ctl, C_BR);
    step();
    check("br_flush_cnt", flush_cnt, 1);
    check("br_lu_cnt", lu_cnt, 0);
    check("br_stall_cnt", stall_cnt, 0);

    // Memory wait of 3 cycles, ready in the 4th
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 check("mw1_ctl", ctl, C_ZERO);
    check("mw1_state", state, 0);
    step();
    check("mw2_ctl", ctl, C_ZERO);
    check("mw2_state", state, 1);
    step();
    check("mw3_ctl", ctl, C_ZERO);
    step();
    check("mw3_stall_cnt", stall_cnt, 3);
    mem_ready = 1'b1;
    #1 check("mw4_ctl", ctl, C_RUN);
    step();
    check("mw_done_state", state, 0);
    check("mw_done_err", mem_err, 0);
    check("mw_done_stall", stall_cnt, 3);

    // Watchdog: 4 consecutive not-ready cycles
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    step(); step(); step();
    check("wd3_state", state, 1);
    check("wd3_err", mem_err, 0);
    step();
    check("wd_state", state, 2);
    check("wd_err", mem_err, 1);
    check("wd_stall_sat", stall_cnt, 3);
    mem_ready = 1'b1; ex_branch_taken = 1'b1;
    #1 check("wd_ready_ctl", ctl, C_ZERO);
    step();
    check("wd_hold_state", state, 2);
    check("wd_no_flush", flush_cnt, 0);
    idle();
    rst = 1'b1;
    #1 check("wd_rst_ctl", ctl, C_ZERO);
    step();
    rst = 1'b0;
    check("wd_rst_state", state, 0);
    check("wd_rst_err", mem_err, 0);
    check("wd_rst_cnts", {stall_cnt, flush_cnt, lu_cnt}, 0);

    // Branch held during a 2-cycle stall, flushed when ready
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1 check("sb1_ctl", ctl, C_ZERO);
    step();
    check("sb2_ctl", ctl, C_ZERO);
    step();
    check("sb_no_flush", flush_cnt, 0);
    mem_ready = 1'b1;
    #1 check("sb3_ctl", ctl, C_BR);
    step();
    check("sb_flush_cnt", flush_cnt, 1);
    check("sb_stall_cnt", stall_cnt, 2);

    // Counter saturation with 5 load-use cycles
    do_reset();
    ex_mem_rd = 1'b1; ex_rd = 5'd9; id_use_rs1 = 1'b1; id_rs1 = 5'd9;
    for (int i = 0; i < 5; i++) step();
    check("sat_lu_cnt", lu_cnt, 3);
    check("sat_stall_cnt", stall_cnt, 3);
    check("sat_ctl", ctl, C_LU);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
